// File: rtl/hub75_pkg.sv
// hub75_pkg: shared default geometry and swap FSM state type for the frame buffer
package hub75_pkg;
   localparam int CH_WIDTH_DEF  = 8;
   localparam int NUM_CH_DEF    = 3;
   localparam int MEM_DEPTH_DEF = 2048;
   typedef enum logic {IDLE, PENDING} swap_state_t;
endpackage

// File: rtl/fb_lane_ram.sv
// fb_lane_ram: simple dual-port RAM for one colour lane, registered read port
// ports: clk, rst (clears only the read register), we/waddr/wdata write port,
//        re/raddr read port, rclr forces the read result to zero, rdata read data
module fb_lane_ram #(
   parameter int WIDTH = 8,
   parameter int AW    = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic             rclr,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [2**AW];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk)
      if (rst || (re && rclr)) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/pingpong_fb.sv
// pingpong_fb: double-buffered frame buffer, writer fills back bank, reader scans display bank
// ports: clk, rst (sync, active-high); w_en/w_ch_en/w_addr/w_data write port (back bank);
//        r_en/r_addr read port (display bank), r_data/r_valid read result;
//        swap_req/frame_sync swap handshake, swap_ack pulse, disp_bank current display bank
// optional: PINGPONG_FB_OUT_REG_EN adds an output register (read latency 2)
module pingpong_fb
   import hub75_pkg::*;
#(
   parameter  int CH_WIDTH   = CH_WIDTH_DEF,
   parameter  int NUM_CH     = NUM_CH_DEF,
   parameter  int MEM_DEPTH  = MEM_DEPTH_DEF,
   localparam int DATA_WIDTH = CH_WIDTH * NUM_CH,
   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic [NUM_CH-1:0]     w_ch_en,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_en,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  r_valid,
   input  logic                  swap_req,
   input  logic                  frame_sync,
   output logic                  swap_ack,
   output logic                  disp_bank
);
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
   swap_state_t state, state_nxt;
   logic fire, rv, rd_oob, wr_ok;
   logic [DATA_WIDTH-1:0] rd_data;
   assign rd_oob = {1'b0, r_addr} >= DEPTH;
   assign wr_ok  = w_en && !rst && ({1'b0, w_addr} < DEPTH);
   // a request seen in IDLE only arms the swap; the toggle needs a later frame_sync
   always_comb begin
      fire      = (state == PENDING) && frame_sync;
      state_nxt = (state == IDLE) ? (swap_req ? PENDING : IDLE) : (frame_sync ? IDLE : PENDING);
   end
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         disp_bank <= 1'b0;
         swap_ack  <= 1'b0;
         rv        <= 1'b0;
      end else begin
         state     <= state_nxt;
         disp_bank <= disp_bank ^ fire;
         swap_ack  <= fire;
         rv        <= r_en;
      end
   // bank select is the address MSB, so reader and writer never touch the same word
   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      fb_lane_ram #(.WIDTH(CH_WIDTH), .AW(ADDR_WIDTH + 1)) u_ram (
         .clk   (clk),
         .rst   (rst),
         .we    (wr_ok && w_ch_en[k]),
         .waddr ({~disp_bank, w_addr}),
         .wdata (w_data[k*CH_WIDTH +: CH_WIDTH]),
         .re    (r_en),
         .rclr  (rd_oob),
         .raddr ({disp_bank, r_addr}),
         .rdata (rd_data[k*CH_WIDTH +: CH_WIDTH])
      );
   end
`ifdef PINGPONG_FB_OUT_REG_EN
   logic [DATA_WIDTH-1:0] rd_q;
   logic                  rv_q;
   always_ff @(posedge clk)
      if (rst) begin
         rd_q <= '0;
         rv_q <= 1'b0;
      end else begin
         rd_q <= rd_data;
         rv_q <= rv;
      end
   assign r_data  = rd_q;
   assign r_valid = rv_q;
`else
   assign r_data  = rd_data;
   assign r_valid = rv;
`endif
endmodule

// File: tb/tb_pingpong_fb.sv
// tb_pingpong_fb: directed and randomized checks of pingpong_fb against a word-level model
module tb_pingpong_fb;
   localparam int MD = 200;
`ifdef PINGPONG_FB_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic clk = 0, rst = 1, w_en = 0, r_en = 0, swap_req = 0, frame_sync = 0;
   logic [2:0]  w_ch_en = 0;
   logic [7:0]  w_addr = 0, r_addr = 0;
   logic [23:0] w_data = 0;
   logic [23:0] r_data;
   logic        r_valid, swap_ack, disp_bank;
   int vec = 0, fails = 0, acks = 0;
   logic [23:0] mem [2][256];
   logic [2:0]  kn  [2][256];
   int bank = 0;
   bit pend = 0, ack_e = 0, v1 = 0, v2 = 0, k1 = 1, k2 = 1;
   logic [23:0] d1 = 0, d2 = 0, x19;
   pingpong_fb #(.MEM_DEPTH(MD)) dut (
      .clk(clk), .rst(rst), .w_en(w_en), .w_ch_en(w_ch_en), .w_addr(w_addr), .w_data(w_data),
      .r_en(r_en), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
      .swap_req(swap_req), .frame_sync(frame_sync), .swap_ack(swap_ack), .disp_bank(disp_bank)
   );
   always #5 clk = ~clk;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      vec++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   // one clock: model consumes the inputs present at the edge, then outputs are compared
   task automatic step();
      logic [23:0] rd;
      bit rk, fire;
      @(posedge clk);
      if (rst) begin
         pend = 0; bank = 0; ack_e = 0;
         v1 = 0; v2 = 0; d1 = 0; d2 = 0; k1 = 1; k2 = 1;
      end else begin
         rd = (r_addr < MD) ? mem[bank][r_addr] : 24'h0;
         rk = (r_addr >= MD) || (kn[bank][r_addr] == 3'b111);
         if (w_en && w_addr < MD)
            for (int k = 0; k < 3; k++)
               if (w_ch_en[k]) begin
                  mem[1-bank][w_addr][k*8 +: 8] = w_data[k*8 +: 8];
                  kn[1-bank][w_addr][k] = 1'b1;
               end
         v2 = v1; d2 = d1; k2 = k1;
         v1 = r_en;
         if (r_en) begin d1 = rd; k1 = rk; end
         fire = pend && frame_sync;
         ack_e = fire;
         if (fire) begin bank ^= 1; pend = 0; end
         else if (swap_req) pend = 1;
      end
      #1;
      chk("r_valid", r_valid, LAT == 2 ? v2 : v1);
      if (LAT == 2 ? k2 : k1) chk("r_data", r_data, LAT == 2 ? d2 : d1);
      chk("disp_bank", disp_bank, bank);
      chk("swap_ack", swap_ack, ack_e);
      acks += swap_ack;
   endtask
   task automatic wr(input logic [7:0] a, input logic [23:0] d, input logic [2:0] m);
      w_en = 1; w_addr = a; w_data = d; w_ch_en = m;
      step();
      w_en = 0;
   endtask
   task automatic rd(input logic [7:0] a);
      r_en = 1; r_addr = a;
      step();
      r_en = 0;
      repeat (LAT - 1) step();
   endtask
   task automatic swap();
      swap_req = 1; step(); swap_req = 0;
      frame_sync = 1; step(); frame_sync = 0;
      step();
   endtask
   initial begin
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 256; a++) begin mem[b][a] = 0; kn[b][a] = 0; end
      repeat (2) step();
      rst = 0;
      for (int a = 0; a < 4; a++) begin
         rd(8'(a));
         chk("rst_read_valid", r_valid, 1);
      end
      step();
      chk("rst_valid_drop", r_valid, 0);
      for (int b = 0; b < 2; b++) begin
         for (int a = 0; a < MD; a++) wr(8'(a), 24'($urandom), 3'b111);
         swap();
      end
      wr(0, 24'hDEADBE, 3'b111);
      wr(1, 24'hEFB00B, 3'b111);
      swap();
      chk("swap_bank1", disp_bank, 1);
      rd(0); chk("rd_deadbe", r_data, 24'hDEADBE);
      rd(1); chk("rd_efb00b", r_data, 24'hEFB00B);
      wr(5, 24'h112233, 3'b111);
      wr(5, 24'hAABBCC, 3'b010);
      swap();
      rd(5); chk("lane_mask", r_data, 24'h11BB33);
      acks = 0;
      swap_req = 1; frame_sync = 1; step(); swap_req = 0; frame_sync = 0;
      chk("same_cycle_no_toggle", disp_bank, 0);
      step();
      swap_req = 1; step(); swap_req = 0;
      frame_sync = 1; step(); frame_sync = 0;
      chk("delayed_toggle", disp_bank, 1);
      repeat (3) step();
      chk("single_ack", acks, 1);
      swap();
      swap_req = 1; step(); swap_req = 0;
      rst = 1; w_en = 1; w_addr = 7; w_data = 24'h777777; w_ch_en = 3'b111; step();
      rst = 0; w_en = 0;
      acks = 0;
      frame_sync = 1; step(); frame_sync = 0;
      repeat (2) step();
      chk("rst_drop_bank", disp_bank, 0);
      chk("rst_drop_ack", acks, 0);
      x19 = 24'($urandom);
      wr(19, x19, 3'b111);
      wr(220, 24'h5A5A5A, 3'b111);
      swap();
      rd(220); chk("oob_zero", r_data, 0); chk("oob_valid", r_valid, 1);
      rd(19); chk("addr19_kept", r_data, x19);
      for (int i = 0; i < 2000; i++) begin
         rst        = ($urandom_range(0, 299) == 0);
         w_en       = $urandom_range(0, 1) == 1;
         w_ch_en    = 3'($urandom);
         w_addr     = 8'($urandom_range(0, 255));
         w_data     = 24'($urandom);
         r_en       = $urandom_range(0, 2) != 0;
         r_addr     = 8'($urandom_range(0, 255));
         swap_req   = $urandom_range(0, 7) == 0;
         frame_sync = $urandom_range(0, 9) == 0;
         step();
      end
      rst = 0; w_en = 0; r_en = 0; swap_req = 0; frame_sync = 0;
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
      $finish;
   end
endmodule
